measure_sequencer: RTL and testbench
====================================

Name: measure_sequencer

Overview:
- Acquisition sequencer that generates the measurement counters consumed by the Stokes/anti-Stokes switch controller and the accumulators.
- On each laser sync trigger, it sweeps cnt_point over the sample window, then over a guard tail. It advances cnt_measure per shot and signals completion after MEASURES shots.
- Sits between the laser/trigger front end and the switch/accumulator logic.

Parameters:
- TAIL_CYCLES, 50, guard cycles after the sample window per shot (cnt_point keeps counting through the tail).
- PW, 11, cnt_point / POINTS width.
- MW, 17, cnt_measure / MEASURES width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin an accumulation run
- abort  in  1  single-cycle request to cancel the run
- trig  in  1  laser sync pulse, one cycle wide
- POINTS  in  11  samples per shot
- MEASURES  in  17  shots per run
- cnt_point  out  11  point counter
- cnt_measure  out  17  shot counter
- acq_en  out  1  high while the sample window is active
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse at run completion
- cfg_err  out  1  one-cycle pulse when start is rejected
- overrun  out  1  sticky: a trig arrived outside ARM during a run
- chan  out  1  current Stokes/anti-Stokes channel (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: cnt_point, cnt_measure, acq_en, busy, done, cfg_err, overrun, chan.
- Configuration:
  - POINTS and MEASURES are latched on an accepted start.
  - Changes to them mid-run have no effect.
- Start rejection:
  - A start in IDLE with POINTS==0, MEASURES==0, or POINTS > 2047-TAIL_CYCLES is rejected.
  - cfg_err pulses the next cycle and the state stays IDLE.
- Accepted start:
  - Next cycle: state ARM, busy=1, overrun cleared, counters 0.
  - start while busy is ignored.
- States:
  - IDLE: wait for start.
  - ARM: wait for trig. When trig=1, the next cycle enters ACQ with cnt_point=0 and acq_en=1.
  - ACQ:
    - cnt_point increments by 1 each cycle and acq_en=1.
    - At cnt_point==POINTS-1, the next cycle enters TAIL with cnt_point=POINTS and acq_en=0.
    - Exactly POINTS cycles have acq_en=1 per shot.
  - TAIL:
    - cnt_point increments each cycle.
    - At cnt_point==POINTS+TAIL_CYCLES-1:
      - If cnt_measure==MEASURES-1: enter DONE.
      - Else: cnt_measure+1, cnt_point=0, enter ARM.
  - DONE (one cycle):
    - done=1, busy=0, counters cleared to 0.
    - Next state IDLE.
- Trigger timing:
  - trig is sampled only in ARM.
  - trig in ACQ or TAIL during a run sets overrun and is otherwise ignored (no restart of the shot).
  - trig in IDLE is ignored and does not set overrun.
- Counter values:
  - cnt_point never exceeds POINTS+TAIL_CYCLES-1.
  - cnt_measure never exceeds MEASURES-1.
  - No wrap-around occurs within widths.
- Abort:
  - abort in any non-IDLE state: next cycle IDLE, counters 0, acq_en=0, busy=0, no done.
  - overrun holds its value.
  - abort has priority over every other event in the same cycle, including trig, tail end, and DONE.
- Reset mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: SWITCH_TRACK_EN.
- When defined:
  - chan toggles on the clock edge where cnt_measure==MEASURES-1 and cnt_point==2, matching the switch controller's toggle point.
  - chan mirrors the external switch state.
  - done is qualified with the chan value for the completed run; chan does not change in the DONE cycle.
- When undefined: chan is tied to 0 and no tracking logic is built.

Decomposition:
- Package meas_pkg:
  - state enum {IDLE, ARM, ACQ, TAIL, DONE}
  - widths PW, MW
  - TAIL_CYCLES default
  - max-POINTS constant
- Sub-module: shot_counter, the point counter with window/tail compare producing window_end and tail_end. It is instantiated once.

Test Plan:
- POINTS=4, MEASURES=2, TAIL=3, start, then trig at cycles 5 and 20 -> acq_en high 4 cycles per shot; cnt_point runs 0..6 per shot; cnt_measure 0 then 1; done pulses once, one cycle after the second shot's cnt_point==6.
- start with POINTS=0 or MEASURES=0 -> cfg_err one pulse, busy stays 0, counters stay 0.
- trig during ACQ of shot 0 (POINTS=8) -> overrun=1 sticky, shot not restarted, run completes normally; next start clears overrun.
- abort asserted in the same cycle as the TAIL end on the last shot -> no done, IDLE next cycle, all counters 0.
- rst_n low mid-ACQ -> all outputs 0 immediately without waiting for clk; a subsequent start behaves normally.
- SWITCH_TRACK_EN defined, MEASURES=3, two back-to-back runs -> chan toggles exactly once per run, at cnt_measure==2 and cnt_point==2.

Source files
------------

// File: rtl/meas_pkg.sv
// meas_pkg: shared types and constants for the measurement sequencer.
//   PW / MW          widths of cnt_point / POINTS and cnt_measure / MEASURES
//   TAIL_CYCLES_DEF  default guard-tail length after the sample window
//   MAX_POINTS_DEF   largest POINTS accepted with the default tail
//   state_e          sequencer FSM states
package meas_pkg;

    localparam int unsigned PW              = 11;
    localparam int unsigned MW              = 17;
    localparam int unsigned TAIL_CYCLES_DEF = 50;

    // Largest value the point counter can hold.
    localparam int unsigned CNT_POINT_MAX   = (1 << PW) - 1;
    localparam int unsigned MAX_POINTS_DEF  = CNT_POINT_MAX - TAIL_CYCLES_DEF;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StAcq,
        StTail,
        StDone
    } state_e;

    // POINTS limit for a given tail so that POINTS+tail-1 never wraps cnt_point.
    function automatic logic [PW-1:0] max_points(input int unsigned tail);
        return PW'(CNT_POINT_MAX - tail);
    endfunction

endpackage

// File: rtl/measure_sequencer_if.sv
// measure_sequencer_if: control/counter bundle between the trigger front end
// (master) and the measurement sequencer (slave).
//   start, abort, trig       run control and laser sync (master -> slave)
//   POINTS, MEASURES         run configuration (master -> slave)
//   cnt_point, cnt_measure   measurement counters (slave -> master)
//   acq_en, busy, done       run status (slave -> master)
//   cfg_err, overrun, chan   error flags and tracked switch channel
interface measure_sequencer_if;
    import meas_pkg::*;

    logic          start;
    logic          abort;
    logic          trig;
    logic [PW-1:0] POINTS;
    logic [MW-1:0] MEASURES;
    logic [PW-1:0] cnt_point;
    logic [MW-1:0] cnt_measure;
    logic          acq_en;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          overrun;
    logic          chan;

    modport master (
        output start, abort, trig, POINTS, MEASURES,
        input  cnt_point, cnt_measure, acq_en, busy, done, cfg_err, overrun, chan
    );

    modport slave (
        input  start, abort, trig, POINTS, MEASURES,
        output cnt_point, cnt_measure, acq_en, busy, done, cfg_err, overrun, chan
    );

endinterface

// File: rtl/shot_counter.sv
// shot_counter: per-shot point counter with sample-window and guard-tail compares.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear to 0 (wins over inc)
//   inc          advance the counter by one
//   points       latched samples-per-shot
//   cnt_point    current point count
//   window_end   cnt_point == points-1 (last sample of the window)
//   tail_end     cnt_point == points+TAIL_CYCLES-1 (last guard cycle)
module shot_counter
    import meas_pkg::*;
#(
    parameter int unsigned TAIL_CYCLES = TAIL_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [PW-1:0] points,
    output logic [PW-1:0] cnt_point,
    output logic          window_end,
    output logic          tail_end
);

    localparam logic [PW-1:0] TailM1 = PW'(TAIL_CYCLES - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // points is at least 1 during a run, and POINTS+TAIL_CYCLES-1 fits in PW bits.
    assign window_end = (cnt_q == points - PW'(1));
    assign tail_end   = (cnt_q == points + TailM1);
    assign cnt_point  = cnt_q;

endmodule

// File: rtl/measure_sequencer.sv
// measure_sequencer: acquisition sequencer driving the point/shot counters for
// the Stokes/anti-Stokes switch controller and accumulators. Each laser trig
// in ARM starts one shot: POINTS sample cycles (acq_en=1) then TAIL_CYCLES
// guard cycles; after MEASURES shots done pulses for one cycle.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          measure_sequencer_if.slave: start/abort/trig, POINTS/MEASURES,
//                cnt_point/cnt_measure, acq_en/busy/done, cfg_err/overrun/chan
// Build option: define SWITCH_TRACK_EN to track the switch channel on chan;
// otherwise chan is tied to 0.
module measure_sequencer
    import meas_pkg::*;
#(
    parameter int unsigned TAIL_CYCLES = TAIL_CYCLES_DEF
) (
    input logic                clk,
    input logic                rst_n,
    measure_sequencer_if.slave bus
);

    localparam logic [PW-1:0] MaxPoints = max_points(TAIL_CYCLES);

    state_e        state_q;
    logic [PW-1:0] points_q;
    logic [MW-1:0] measures_q;
    logic [MW-1:0] cnt_measure_q;
    logic          acq_en_q;
    logic          busy_q;
    logic          done_q;
    logic          cfg_err_q;
    logic          overrun_q;
    logic          chan_q;

    logic [PW-1:0] cnt_point;
    logic          window_end;
    logic          tail_end;
    logic          cfg_bad;
    logic          last_shot;
    logic          in_shot;
    logic          abort_run;
    logic          cnt_clr;
    logic          cnt_inc;

    assign cfg_bad   = (bus.POINTS == '0) || (bus.MEASURES == '0) || (bus.POINTS > MaxPoints);
    assign last_shot = (cnt_measure_q == measures_q - MW'(1));
    assign in_shot   = (state_q == StAcq) || (state_q == StTail);
    assign abort_run = bus.abort && (state_q != StIdle);

    // Counter is zero on every entry to ARM/IDLE, so only the tail end and
    // abort need an explicit clear.
    assign cnt_clr = abort_run || ((state_q == StTail) && tail_end);
    assign cnt_inc = in_shot;

    shot_counter #(
        .TAIL_CYCLES (TAIL_CYCLES)
    ) u_shot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .inc        (cnt_inc),
        .points     (points_q),
        .cnt_point  (cnt_point),
        .window_end (window_end),
        .tail_end   (tail_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            points_q      <= '0;
            measures_q    <= '0;
            cnt_measure_q <= '0;
            acq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (abort_run) begin
                // Abort beats trig, tail end and DONE; overrun is kept.
                state_q       <= StIdle;
                cnt_measure_q <= '0;
                acq_en_q      <= 1'b0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            if (cfg_bad) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                state_q       <= StArm;
                                busy_q        <= 1'b1;
                                overrun_q     <= 1'b0;
                                cnt_measure_q <= '0;
                                points_q      <= bus.POINTS;
                                measures_q    <= bus.MEASURES;
                            end
                        end
                    end
                    StArm: begin
                        if (bus.trig) begin
                            state_q  <= StAcq;
                            acq_en_q <= 1'b1;
                        end
                    end
                    StAcq: begin
                        if (bus.trig) begin
                            overrun_q <= 1'b1;
                        end
                        if (window_end) begin
                            state_q  <= StTail;
                            acq_en_q <= 1'b0;
                        end
                    end
                    StTail: begin
                        if (bus.trig) begin
                            overrun_q <= 1'b1;
                        end
                        if (tail_end) begin
                            if (last_shot) begin
                                state_q       <= StDone;
                                done_q        <= 1'b1;
                                busy_q        <= 1'b0;
                                cnt_measure_q <= '0;
                            end else begin
                                state_q       <= StArm;
                                cnt_measure_q <= cnt_measure_q + MW'(1);
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

`ifdef SWITCH_TRACK_EN
    // Mirror the switch controller: it flips once per run at point 2 of the
    // last shot. Only ACQ/TAIL can toggle, so chan is stable in the DONE cycle
    // and done is seen alongside the completed run's channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q <= 1'b0;
        end else if (!abort_run && in_shot && last_shot && (cnt_point == PW'(2))) begin
            chan_q <= ~chan_q;
        end
    end
`else
    assign chan_q = 1'b0;
`endif

    assign bus.cnt_point   = cnt_point;
    assign bus.cnt_measure = cnt_measure_q;
    assign bus.acq_en      = acq_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.chan        = chan_q;

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer with TAIL_CYCLES=3.
module tb_measure_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    measure_sequencer_if bus ();

    measure_sequencer #(
        .TAIL_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_run(input string tag, input int cp, input int cm, input logic acq,
                           input logic bsy, input logic dn);
        chk({tag, ".cnt_point"}, 32'(bus.cnt_point), cp);
        chk({tag, ".cnt_measure"}, 32'(bus.cnt_measure), cm);
        chk({tag, ".acq_en"}, 32'(bus.acq_en), 32'(acq));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    endtask

    task automatic chk_zero(input string tag);
        chk_run(tag, 0, 0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 0);
        chk({tag, ".overrun"}, 32'(bus.overrun), 0);
        chk({tag, ".chan"}, 32'(bus.chan), 0);
    endtask

    task automatic do_start(input int p, input int m);
        bus.POINTS   = 11'(p);
        bus.MEASURES = 17'(m);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_trig();
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.trig     = 1'b0;
        bus.POINTS   = '0;
        bus.MEASURES = '0;

        // Reset state
        #3;
        chk_zero("reset");
        #10 rst_n = 1'b1;
        tick();
        chk_zero("post_reset");

        // Basic run: POINTS=4, MEASURES=2, tail 3 -> cnt_point 0..6 per shot
        do_start(4, 2);
        chk_run("arm0", 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_run("arm0_wait", 0, 0, 1'b0, 1'b1, 1'b0);
        do_trig();
        for (int i = 0; i < 7; i++) begin
            chk_run($sformatf("shot0_c%0d", i), i, 0, (i < 4), 1'b1, 1'b0);
            tick();
        end
        chk_run("arm1", 0, 1, 1'b0, 1'b1, 1'b0);
        bus.POINTS = 11'd9;  // mid-run change must be ignored
        tick();
        tick();
        do_trig();
        for (int i = 0; i < 7; i++) begin
            chk_run($sformatf("shot1_c%0d", i), i, 1, (i < 4), 1'b1, 1'b0);
            tick();
        end
        chk_run("done", 0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_run("after_done", 0, 0, 1'b0, 1'b0, 1'b0);

        // Start rejection
        do_start(0, 2);
        chk("rej_p0.cfg_err", 32'(bus.cfg_err), 1);
        chk("rej_p0.busy", 32'(bus.busy), 0);
        tick();
        chk("rej_p0.cfg_err_clr", 32'(bus.cfg_err), 0);
        do_start(4, 0);
        chk("rej_m0.cfg_err", 32'(bus.cfg_err), 1);
        chk_run("rej_m0", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        do_start(2045, 1);
        chk("rej_pmax.cfg_err", 32'(bus.cfg_err), 1);
        chk("rej_pmax.busy", 32'(bus.busy), 0);
        tick();
        do_start(2044, 1);
        chk("acc_pmax.cfg_err", 32'(bus.cfg_err), 0);
        chk("acc_pmax.busy", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_run("acc_pmax_abort", 0, 0, 1'b0, 1'b0, 1'b0);

        // trig in IDLE does not set overrun
        do_trig();
        chk("idle_trig.overrun", 32'(bus.overrun), 0);
        chk("idle_trig.busy", 32'(bus.busy), 0);

        // Overrun: trig during ACQ, shot not restarted
        do_start(8, 1);
        do_trig();
        chk_run("ovr_acq0", 0, 0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        do_trig();
        chk_run("ovr_after", 3, 0, 1'b1, 1'b1, 1'b0);
        chk("ovr.overrun", 32'(bus.overrun), 1);
        for (int i = 0; i < 7; i++) tick();
        chk_run("ovr_tail_end", 10, 0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_run("ovr_done", 0, 0, 1'b0, 1'b0, 1'b1);
        chk("ovr_done.overrun", 32'(bus.overrun), 1);
        tick();
        do_trig();
        chk("ovr_sticky", 32'(bus.overrun), 1);
        do_start(4, 2);
        chk("ovr_cleared", 32'(bus.overrun), 0);

        // Abort coincident with the last shot's tail end
        do_trig();
        for (int i = 0; i < 7; i++) tick();
        chk_run("ab_arm1", 0, 1, 1'b0, 1'b1, 1'b0);
        do_trig();
        for (int i = 0; i < 6; i++) tick();
        chk_run("ab_tail_end", 6, 1, 1'b0, 1'b1, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_run("ab_idle", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_run("ab_no_done", 0, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-ACQ
        do_start(4, 2);
        do_trig();
        tick();
        chk_run("rst_pre", 1, 0, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        #2 rst_n = 1'b1;
        tick();
        do_start(4, 2);
        chk_run("rst_restart", 0, 0, 1'b0, 1'b1, 1'b0);
        do_trig();
        chk_run("rst_restart_acq", 0, 0, 1'b1, 1'b1, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_run("rst_restart_abort", 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef SWITCH_TRACK_EN
        // Channel tracking: one toggle per run, at cnt_measure==2, cnt_point==2
        for (int r = 0; r < 2; r++) begin
            int   toggles;
            logic prev;
            toggles = 0;
            do_start(4, 3);
            prev = bus.chan;
            for (int s = 0; s < 3; s++) begin
                do_trig();
                for (int k = 0; k < 7; k++) begin
                    if (bus.chan !== prev) begin
                        toggles++;
                        chk($sformatf("chan%0d.cm", r), 32'(bus.cnt_measure), 2);
                        chk($sformatf("chan%0d.cp", r), 32'(bus.cnt_point), 3);
                    end
                    prev = bus.chan;
                    tick();
                end
            end
            chk($sformatf("chan%0d.done", r), 32'(bus.done), 1);
            chk($sformatf("chan%0d.done_stable", r), 32'(bus.chan), 32'(prev));
            chk($sformatf("chan%0d.toggles", r), 32'(toggles), 1);
            chk($sformatf("chan%0d.value", r), 32'(bus.chan), (r == 0) ? 1 : 0);
            tick();
        end
`else
        do_start(4, 1);
        do_trig();
        for (int k = 0; k < 7; k++) tick();
        chk("chan_off.done", 32'(bus.done), 1);
        chk("chan_off.chan", 32'(bus.chan), 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
